// File: rtl/jtag_cmd_master.sv
// jtag_cmd_master: one-command-at-a-time JTAG TAP sequencer with programmable TCK divider.
module jtag_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [5:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  input  logic              jtag_tdo,
  output logic              jtag_trst_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [6:0] MAX_LEN = 7'(DATA_W);
  localparam int SW = $clog2(DATA_W);
  state_t state, state_n;
  logic [7:0] cnt;
  logic [5:0] idx, nidx, len_q, len_n, t_last;
  logic [1:0] op_q, op_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic accept, legal, div_end, last, tms_n, tdi_n, cur_shift;
  // shift bits start after the Select/Capture prefix: 4 TCK for IR, 3 for DR
  function automatic logic [5:0] pre_of(input logic [1:0] op);
    return op == 2'b01 ? 6'd4 : 6'd3;
  endfunction
  function automatic logic shift_of(input logic [1:0] op, input logic [5:0] len, input logic [5:0] i);
    return (op == 2'b01 || op == 2'b10) && i >= pre_of(op) && i < pre_of(op) + len;
  endfunction
  function automatic logic tms_of(input logic [1:0] op, input logic [5:0] len, input logic [5:0] i);
    logic [5:0] e;
    e = pre_of(op) + len;
    return op == 2'b00 ? i < 6'd5 :
           op == 2'b11 ? 1'b0 :
           (i < pre_of(op) - 6'd2 || i == e - 6'd1 || i == e);
  endfunction
  always_comb begin
    accept    = cmd_valid && state == IDLE;
    legal     = cmd_op == 2'b00 || (cmd_len != 6'd0 && {1'b0, cmd_len} <= MAX_LEN);
    op_n      = accept ? cmd_op : op_q;
    len_n     = accept ? cmd_len : len_q;
    data_n    = accept ? cmd_data : data_q;
    nidx      = accept ? 6'd0 : idx + 6'd1;
    tms_n     = tms_of(op_n, len_n, nidx);
    tdi_n     = shift_of(op_n, len_n, nidx) && data_n[SW'(nidx - pre_of(op_n))];
    cur_shift = shift_of(op_q, len_q, idx);
    div_end   = cnt == DIV_M1;
    t_last    = op_q == 2'b00 ? 6'd5 : op_q == 2'b01 ? len_q + 6'd5 :
                op_q == 2'b10 ? len_q + 6'd4 : len_q - 6'd1;
    last      = idx == t_last;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = legal ? LOW : RESP;
      LOW:     if (div_end) state_n = HIGH;
      HIGH:    if (div_end) state_n = last ? RESP : LOW;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  assign cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      op_q        <= '0;
      len_q       <= '0;
      data_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      jtag_tck    <= 1'b0;
      jtag_tms    <= 1'b1;
      jtag_tdi    <= 1'b0;
      jtag_trst_n <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt       <= '0;
          idx       <= '0;
          op_q      <= cmd_op;
          len_q     <= cmd_len;
          data_q    <= cmd_data;
          rsp_data  <= '0;
          rsp_err   <= !legal;
          rsp_valid <= !legal;
          if (legal) begin
            jtag_tms    <= tms_n;
            jtag_tdi    <= tdi_n;
            jtag_trst_n <= cmd_op != 2'b00;
          end
        end
        LOW: begin
          cnt <= div_end ? 8'd0 : cnt + 8'd1;
          if (div_end) jtag_tck <= 1'b1;
        end
        HIGH: begin
          if (cnt == 8'd0 && cur_shift) rsp_data[SW'(idx - pre_of(op_q))] <= jtag_tdo;
          cnt <= div_end ? 8'd0 : cnt + 8'd1;
          if (div_end) begin
            jtag_tck <= 1'b0;
            if (last) begin
              rsp_valid   <= 1'b1;
              jtag_trst_n <= 1'b1;
            end else begin
              idx      <= nidx;
              jtag_tms <= tms_n;
              jtag_tdi <= tdi_n;
            end
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_cmd_master.sv
// tb_jtag_cmd_master: directed checks of the JTAG command sequencer at CLK_DIV=2, DATA_W=32.
module tb_jtag_cmd_master;
  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_data;
  logic jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, jtag_trst_n;
  logic tdo_loop = 1'b0, tdo_const = 1'b0;
  int checks = 0, errors = 0;
  int tck_cnt = 0;
  logic [63:0] tms_log = '0, tdi_log = '0;
  int lat, trst_lo, bad;
  assign jtag_tdo = tdo_loop ? jtag_tdi : tdo_const;
  always #5 clk = ~clk;
  jtag_cmd_master #(.CLK_DIV(2), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .jtag_trst_n(jtag_trst_n)
  );
  always @(posedge jtag_tck) begin
    if (tck_cnt < 64) begin
      tms_log[tck_cnt] = jtag_tms;
      tdi_log[tck_cnt] = jtag_tdi;
    end
    tck_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr_logs();
    tck_cnt = 0;
    tms_log = '0;
    tdi_log = '0;
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         output int l, output int tl);
    clr_logs();
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    l = 0; tl = 0;
    for (int c = 1; c <= 400 && l == 0; c++) begin
      if (!jtag_trst_n) tl++;
      if (rsp_valid) l = c;
      else begin @(posedge clk); #1; end
    end
  endtask
  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("cmd_ready_after_handshake", 64'(cmd_ready), 64'd1);
  endtask
  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_pins", 64'({jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n}), 64'b0101);
    chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    chk("no_tck_after_reset", 64'(tck_cnt), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("idle_reset_pins", 64'({jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n, rsp_valid}), 64'b01010);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // TAP reset
    run_cmd(2'b00, 6'd0, 32'h0, lat, trst_lo);
    chk("tap_latency", 64'(lat), 64'd25);
    chk("tap_trst_low_cycles", 64'(trst_lo), 64'd24);
    chk("tap_tck_count", 64'(tck_cnt), 64'd6);
    chk("tap_tms_seq", tms_log, 64'h1F);
    chk("tap_rsp", 64'({rsp_err, jtag_trst_n, jtag_tck, rsp_data}), {31'd0, 3'b010, 32'd0});
    handshake();
    // IR shift with loopback, then backpressure
    tdo_loop = 1'b1;
    run_cmd(2'b01, 6'd5, 32'h15, lat, trst_lo);
    chk("ir_latency", 64'(lat), 64'd45);
    chk("ir_tck_count", 64'(tck_cnt), 64'd11);
    chk("ir_tms_seq", tms_log, 64'h303);
    chk("ir_tdi_seq", tdi_log, 64'h150);
    chk("ir_rsp_data", 64'(rsp_data), 64'h15);
    chk("ir_tms_idle_level", 64'(jtag_tms), 64'd0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (rsp_data !== 32'h15 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || jtag_tck !== 1'b0) bad++;
    end
    chk("backpressure_hold", 64'(bad), 64'd0);
    handshake();
    // DR shift, TDO tied high
    tdo_loop = 1'b0;
    tdo_const = 1'b1;
    run_cmd(2'b10, 6'd32, 32'h0, lat, trst_lo);
    chk("dr_latency", 64'(lat), 64'd149);
    chk("dr_tck_count", 64'(tck_cnt), 64'd37);
    chk("dr_tms_seq", tms_log, 64'h0000_000C_0000_0001);
    chk("dr_tdi_zero", tdi_log, 64'd0);
    chk("dr_rsp", 64'({rsp_err, rsp_data}), 64'h0_FFFF_FFFF);
    handshake();
    // illegal lengths
    run_cmd(2'b10, 6'd0, 32'hFFFF_FFFF, lat, trst_lo);
    chk("len0_latency", 64'(lat), 64'd1);
    chk("len0_rsp", 64'({rsp_err, rsp_data}), 64'h1_0000_0000);
    chk("len0_no_tck", 64'(tck_cnt), 64'd0);
    handshake();
    run_cmd(2'b10, 6'd33, 32'hFFFF_FFFF, lat, trst_lo);
    chk("len33_latency", 64'(lat), 64'd1);
    chk("len33_rsp", 64'({rsp_err, rsp_data}), 64'h1_0000_0000);
    chk("len33_no_tck", 64'(tck_cnt), 64'd0);
    handshake();
    // idle clocks: no capture even with TDO high
    run_cmd(2'b11, 6'd3, 32'hFFFF_FFFF, lat, trst_lo);
    chk("idle_latency", 64'(lat), 64'd13);
    chk("idle_tck_count", 64'(tck_cnt), 64'd3);
    chk("idle_tms_tdi", tms_log | tdi_log, 64'd0);
    chk("idle_rsp", 64'({rsp_err, rsp_data}), 64'd0);
    handshake();
    // async reset during shift bit 3 of a DR shift (TCK index 6)
    clr_logs();
    cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'hFF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 200 && tck_cnt < 7; c++) begin @(posedge clk); #1; end
    chk("dr_bit3_reached", 64'({jtag_tck, jtag_tms, jtag_tdi}), 64'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pins", 64'({jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n, rsp_valid}), 64'b01010);
    #3 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("no_rsp_after_reset", 64'(bad), 64'd0);
    chk("no_tck_after_reset_abort", 64'(tck_cnt), 64'd7);
    chk("ready_after_abort", 64'(cmd_ready), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
